// File: rtl/phy_pkg.sv
// Shared phy definitions: comma symbol, lane word width and receiver alignment states.
package phy_pkg;

    localparam logic [7:0] COM_SYMBOL = 8'hBC;
    localparam int         WORD_W     = 9;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/com_detector.sv
// Forms the 8-bit window ending at the current serial bit and flags the COM symbol.
module com_detector
    import phy_pkg::*;
(
    input  logic [6:0] sr_low,
    input  logic       data_in,
    output logic [7:0] w,
    output logic       is_com
);

    assign w      = {sr_low, data_in};
    assign is_com = (w == COM_SYMBOL);

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: aligns on COM, locks after LOCK_COUNT aligned COMs, emits {valid, byte}.
// Optional feature: define IDLE_COUNT_EN to add the saturating idle_count output.
module serial_paralelo_rx
    import phy_pkg::*;
#(
    parameter int LOCK_COUNT = 4
)
(
    input  logic              clk32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [WORD_W-1:0] paralelo_out,
    output logic              byte_strobe,
    output logic              active
`ifdef IDLE_COUNT_EN
    ,
    output logic [7:0]        idle_count
`endif
);

    rx_state_t  state_reg;
    rx_state_t  state_next;
    // Only the low 7 history bits are ever read; the window supplies the 8th.
    logic [6:0] sr_reg;
    logic [2:0] bitcnt_reg;
    logic [3:0] comcnt_reg;
    logic [7:0] w;
    logic       is_com;
    logic       boundary;
    logic       lock_hit;

    com_detector u_com_detector (
        .sr_low  (sr_reg),
        .data_in (data_in),
        .w       (w),
        .is_com  (is_com)
    );

    assign boundary = (bitcnt_reg == 3'd7);
    assign lock_hit = (comcnt_reg == 4'(LOCK_COUNT - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SEARCH: begin
                if (is_com) state_next = ALIGN;
            end
            ALIGN: begin
                if (boundary) begin
                    if (!is_com)       state_next = SEARCH;
                    else if (lock_hit) state_next = ACTIVE;
                end
            end
            ACTIVE:  state_next = ACTIVE;
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) state_reg <= SEARCH;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            sr_reg       <= '0;
            bitcnt_reg   <= '0;
            comcnt_reg   <= '0;
            paralelo_out <= '0;
            byte_strobe  <= 1'b0;
            active       <= 1'b0;
        end else begin
            sr_reg      <= w[6:0];
            byte_strobe <= 1'b0;
            case (state_reg)
                SEARCH: begin
                    if (is_com) begin
                        bitcnt_reg <= 3'd0;
                        comcnt_reg <= 4'd1;
                    end
                end
                ALIGN: begin
                    bitcnt_reg <= bitcnt_reg + 3'd1;
                    if (boundary) begin
                        if (!is_com)       comcnt_reg <= 4'd0;
                        else if (lock_hit) active     <= 1'b1;
                        else               comcnt_reg <= comcnt_reg + 4'd1;
                    end
                end
                ACTIVE: begin
                    bitcnt_reg <= bitcnt_reg + 3'd1;
                    if (boundary) begin
                        // Idle COMs go out as an invalid all-zero word.
                        paralelo_out <= is_com ? '0 : {1'b1, w};
                        byte_strobe  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IDLE_COUNT_EN
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            idle_count <= '0;
        end else if (state_reg == ACTIVE && boundary && is_com && idle_count != 8'hFF) begin
            idle_count <= idle_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Scoreboard bench for serial_paralelo_rx: expected words queued as bytes are sent, popped on byte_strobe.
module tb_serial_paralelo_rx;
    import phy_pkg::*;

    logic       clk32f  = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [8:0] paralelo_out;
    logic       byte_strobe;
    logic       active;
`ifdef IDLE_COUNT_EN
    logic [7:0] idle_count;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    logic [8:0] exp_q[$];
    logic       locked      = 1'b0;
    logic [8:0] hold_val    = 9'h000;
    logic [8:0] exp_word;
    int         cyc         = 0;
    int         last_strobe = -1;

    serial_paralelo_rx dut (
        .clk32f       (clk32f),
        .reset        (reset),
        .data_in      (data_in),
        .paralelo_out (paralelo_out),
        .byte_strobe  (byte_strobe),
        .active       (active)
`ifdef IDLE_COUNT_EN
        ,
        .idle_count   (idle_count)
`endif
    );

    always #5 clk32f = ~clk32f;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (locked) exp_q.push_back((b == COM_SYMBOL) ? 9'h000 : {1'b1, b});
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        $display("sent byte %02h locked=%0d active=%0d", b, locked, active);
    endtask

    // Three COMs, then the fourth: active must rise exactly on its last bit.
    task automatic lock_seq(input string tag);
        logic [7:0] com;
        com = COM_SYMBOL;
        for (int k = 0; k < 3; k++) send_byte(com);
        for (int i = 7; i >= 1; i--) send_bit(com[i]);
        check_val({tag, "_active_before_last_bit"}, active, 0);
        send_bit(com[0]);
        check_val({tag, "_active_on_last_bit"}, active, 1);
        locked = 1'b1;
    endtask

    task automatic apply_reset(input int ncyc, input logic chk_now);
        check_val("queue_empty_before_reset", exp_q.size(), 0);
        reset       = 1'b0;
        locked      = 1'b0;
        last_strobe = -1;
        hold_val    = 9'h000;
        exp_q.delete();
        if (chk_now) begin
            #1;
            check_val("async_clear_out", paralelo_out, 0);
            check_val("async_clear_strobe", byte_strobe, 0);
            check_val("async_clear_active", active, 0);
`ifdef IDLE_COUNT_EN
            check_val("async_clear_idle", idle_count, 0);
`endif
        end
        for (int c = 0; c < ncyc; c++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk32f);
            #1;
            check_val("reset_out", paralelo_out, 0);
            check_val("reset_strobe", byte_strobe, 0);
            check_val("reset_active", active, 0);
        end
        reset = 1'b1;
        $display("reset released after %0d cycles", ncyc);
    endtask

    // Scoreboard: every strobe pops one expected word; between strobes the output must hold.
    always @(negedge clk32f) begin
        cyc++;
        if (byte_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_strobe", 1, 0);
                hold_val = paralelo_out;
            end else begin
                exp_word = exp_q.pop_front();
                check_val("word", paralelo_out, exp_word);
                hold_val = exp_word;
                $display("strobe cycle %0d word %03h expected %03h", cyc, paralelo_out, exp_word);
            end
            if (last_strobe >= 0) check_val("strobe_spacing", cyc - last_strobe, 8);
            last_strobe = cyc;
        end else begin
            check_val("hold", paralelo_out, hold_val);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  rbits;
        logic [12:0] s;
        logic        bad;
        logic [7:0]  com;
        com = COM_SYMBOL;

        // 1: reset with random data, then quiet zeros produce nothing.
        apply_reset(3, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        check_val("t1_active_idle", active, 0);

        // 2: random prefix (no accidental COM window), lock, four data bytes.
        do begin
            rbits = 5'($urandom);
            s     = {rbits, com};
            bad   = 1'b0;
            for (int k = 0; k < 5; k++) if (s[12-k -: 8] == com) bad = 1'b1;
        end while (bad);
        for (int i = 4; i >= 0; i--) send_bit(rbits[i]);
        check_val("t2_active_prefix", active, 0);
        lock_seq("t2");
        send_byte(8'hFF);
        send_byte(8'hF5);
        send_byte(8'hFA);
        send_byte(8'hF4);
        @(negedge clk32f);
        #1;

        // 3: broken COM run falls back to SEARCH, then relock.
        apply_reset(1, 1'b0);
        for (int k = 0; k < 3; k++) send_byte(com);
        send_byte(8'h55);
        check_val("t3_active_after_55", active, 0);
        lock_seq("t3");
        send_byte(8'hFE);

        // 4: idle COMs inside data come out as invalid words.
        send_byte(8'hFF);
        send_byte(com);
        send_byte(com);
        send_byte(8'hFB);
`ifdef IDLE_COUNT_EN
        check_val("t4_idle_count", idle_count, 2);
`endif

        // 5: reset mid-byte, relock needs four fresh COMs.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        apply_reset(1, 1'b1);
        lock_seq("t5");
        send_byte(8'h3C);
`ifdef IDLE_COUNT_EN
        check_val("t5_idle_after_reset", idle_count, 0);
`endif

        // 6: long idle run, idle counter saturates, strobes keep coming.
        for (int k = 0; k < 300; k++) begin
            send_byte(com);
`ifdef IDLE_COUNT_EN
            if (k == 253) check_val("t6_idle_254", idle_count, 254);
            if (k == 254) check_val("t6_idle_255", idle_count, 255);
`endif
        end
`ifdef IDLE_COUNT_EN
        check_val("t6_idle_saturated", idle_count, 255);
`endif
        check_val("t6_active_held", active, 1);

        @(negedge clk32f);
        #1;
        check_val("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
